// File: rtl/vslide_issue.sv
// vslide_issue: request sequencer for the streaming input of the vector slide unit.
// Accepts one vslide1up/vslide1down request, reads the source register group one
// 64-bit chunk per cycle and presents each chunk with start/end/byte-enable,
// SEW, direction and scalar sidebands, two cycles after the matching read.
// Optional feature macro: VSLIDE_ISSUE_INSERT_EN (adds req_insert, drives out_insert).
module vslide_issue #(
    parameter int REQ_DATA_WIDTH    = 64,
    parameter int SEW_WIDTH         = 2,
    parameter int REQ_BYTE_EN_WIDTH = 8,
    parameter int ADDR_WIDTH        = 10,
    parameter int VL_WIDTH          = 11
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_WIDTH-1:0]        req_vs2_addr,
    input  logic [REQ_DATA_WIDTH-1:0]    req_scalar,
    input  logic [VL_WIDTH-1:0]          req_vl,
    input  logic [SEW_WIDTH-1:0]         req_sew,
    input  logic                         req_dir,
`ifdef VSLIDE_ISSUE_INSERT_EN
    input  logic                         req_insert,
`endif
    output logic                         rf_rd_en,
    output logic [ADDR_WIDTH-1:0]        rf_rd_addr,
    input  logic [REQ_DATA_WIDTH-1:0]    rf_rd_data,
    output logic                         out_valid,
    output logic                         out_start,
    output logic                         out_end,
    output logic                         out_opSel,
    output logic                         out_insert,
    output logic [SEW_WIDTH-1:0]         out_sew,
    output logic [REQ_DATA_WIDTH-1:0]    out_vec0,
    output logic [REQ_DATA_WIDTH-1:0]    out_vec1,
    output logic [REQ_BYTE_EN_WIDTH-1:0] out_be,
    output logic                         busy
);

    // Byte and chunk counts need three extra bits to hold vl << sew.
    localparam int CW = VL_WIDTH + 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t                       state_r;
    logic [CW-1:0]                cnt_r;
    logic [CW-1:0]                chunks_r;
    logic [REQ_BYTE_EN_WIDTH-1:0] last_be_r;
    logic [SEW_WIDTH-1:0]         sew_r;
    logic                         dir_r;
    logic [REQ_DATA_WIDTH-1:0]    scalar_r;
    logic                         insert_r;

    logic                         rd_en_r;
    logic [ADDR_WIDTH-1:0]        rd_addr_r;

    // Stage 1: sidebands of the chunk whose read is being issued.
    logic                         s1_valid_r;
    logic                         s1_start_r;
    logic                         s1_end_r;
    logic [REQ_BYTE_EN_WIDTH-1:0] s1_be_r;

    // Stage 2: sidebands aligned with rf_rd_data.
    logic                         s2_valid_r;
    logic                         s2_start_r;
    logic                         s2_end_r;
    logic [REQ_BYTE_EN_WIDTH-1:0] s2_be_r;

    logic                         out_valid_r;
    logic                         out_start_r;
    logic                         out_end_r;
    logic                         out_opsel_r;
    logic                         out_insert_r;
    logic [SEW_WIDTH-1:0]         out_sew_r;
    logic [REQ_DATA_WIDTH-1:0]    out_vec0_r;
    logic [REQ_DATA_WIDTH-1:0]    out_vec1_r;
    logic [REQ_BYTE_EN_WIDTH-1:0] out_be_r;

    logic [CW-1:0]                bytes_s;
    logic [CW-1:0]                chunks_s;
    logic [REQ_BYTE_EN_WIDTH-1:0] last_be_s;
    logic                         next_is_last_s;
    logic                         insert_in_s;

`ifdef VSLIDE_ISSUE_INSERT_EN
    assign insert_in_s = req_insert;
`else
    assign insert_in_s = 1'b0;
`endif

    // Request sizing: byte count, chunk count, partial byte enable of the last chunk.
    always_comb begin
        bytes_s        = CW'(req_vl) << req_sew;
        chunks_s       = (bytes_s + CW'(7)) >> 3;
        last_be_s      = '1;
        next_is_last_s = 1'b0;
        if (bytes_s[2:0] == 3'd0) begin
            last_be_s = '1;
        end else begin
            last_be_s = (REQ_BYTE_EN_WIDTH'(1) << bytes_s[2:0]) - REQ_BYTE_EN_WIDTH'(1);
        end
        if ((cnt_r + CW'(2)) == chunks_r) begin
            next_is_last_s = 1'b1;
        end else begin
            next_is_last_s = 1'b0;
        end
    end

    // Sequencer FSM: request capture, read issue and stage-1 sideband generation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            chunks_r   <= '0;
            last_be_r  <= '0;
            sew_r      <= '0;
            dir_r      <= 1'b0;
            scalar_r   <= '0;
            insert_r   <= 1'b0;
            rd_en_r    <= 1'b0;
            rd_addr_r  <= '0;
            s1_valid_r <= 1'b0;
            s1_start_r <= 1'b0;
            s1_end_r   <= 1'b0;
            s1_be_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        sew_r     <= req_sew;
                        dir_r     <= req_dir;
                        scalar_r  <= req_scalar;
                        insert_r  <= insert_in_s;
                        chunks_r  <= chunks_s;
                        last_be_r <= last_be_s;
                    end
                    // A zero-length request is consumed without issuing anything.
                    if (req_valid && (req_vl != '0)) begin
                        state_r    <= READ;
                        cnt_r      <= '0;
                        rd_en_r    <= 1'b1;
                        rd_addr_r  <= req_vs2_addr;
                        s1_valid_r <= 1'b1;
                        s1_start_r <= 1'b1;
                        s1_end_r   <= (chunks_s == CW'(1));
                        s1_be_r    <= (chunks_s == CW'(1)) ? last_be_s : '1;
                    end else begin
                        rd_en_r    <= 1'b0;
                        rd_addr_r  <= '0;
                        s1_valid_r <= 1'b0;
                        s1_start_r <= 1'b0;
                        s1_end_r   <= 1'b0;
                        s1_be_r    <= '0;
                    end
                end
                READ: begin
                    if (cnt_r == (chunks_r - CW'(1))) begin
                        state_r    <= IDLE;
                        rd_en_r    <= 1'b0;
                        rd_addr_r  <= '0;
                        s1_valid_r <= 1'b0;
                        s1_start_r <= 1'b0;
                        s1_end_r   <= 1'b0;
                        s1_be_r    <= '0;
                    end else begin
                        cnt_r      <= cnt_r + CW'(1);
                        rd_en_r    <= 1'b1;
                        // Address wraps naturally at the register-file boundary.
                        rd_addr_r  <= rd_addr_r + ADDR_WIDTH'(1);
                        s1_valid_r <= 1'b1;
                        s1_start_r <= 1'b0;
                        s1_end_r   <= next_is_last_s;
                        s1_be_r    <= next_is_last_s ? last_be_r : '1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    rd_en_r    <= 1'b0;
                    rd_addr_r  <= '0;
                    s1_valid_r <= 1'b0;
                    s1_start_r <= 1'b0;
                    s1_end_r   <= 1'b0;
                    s1_be_r    <= '0;
                end
            endcase
        end
    end

    // Output pipeline: align sidebands with read data, then register the chunk.
    // The captured request fields are safe to use here: a new request can only be
    // captured on the same edge that loads the previous stream's last chunk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_r   <= 1'b0;
            s2_start_r   <= 1'b0;
            s2_end_r     <= 1'b0;
            s2_be_r      <= '0;
            out_valid_r  <= 1'b0;
            out_start_r  <= 1'b0;
            out_end_r    <= 1'b0;
            out_opsel_r  <= 1'b0;
            out_insert_r <= 1'b0;
            out_sew_r    <= '0;
            out_vec0_r   <= '0;
            out_vec1_r   <= '0;
            out_be_r     <= '0;
        end else begin
            s2_valid_r <= s1_valid_r;
            s2_start_r <= s1_start_r;
            s2_end_r   <= s1_end_r;
            s2_be_r    <= s1_be_r;
            if (s2_valid_r) begin
                out_valid_r  <= 1'b1;
                out_start_r  <= s2_start_r;
                out_end_r    <= s2_end_r;
                out_opsel_r  <= dir_r;
                out_insert_r <= insert_r;
                out_sew_r    <= sew_r;
                out_vec0_r   <= rf_rd_data;
                out_vec1_r   <= scalar_r;
                out_be_r     <= s2_be_r;
            end else begin
                out_valid_r  <= 1'b0;
                out_start_r  <= 1'b0;
                out_end_r    <= 1'b0;
                out_opsel_r  <= 1'b0;
                out_insert_r <= 1'b0;
                out_sew_r    <= '0;
                out_vec0_r   <= '0;
                out_vec1_r   <= '0;
                out_be_r     <= '0;
            end
        end
    end

    assign req_ready  = (state_r == IDLE);
    assign rf_rd_en   = rd_en_r;
    assign rf_rd_addr = rd_addr_r;
    assign out_valid  = out_valid_r;
    assign out_start  = out_start_r;
    assign out_end    = out_end_r;
    assign out_opSel  = out_opsel_r;
    assign out_insert = out_insert_r;
    assign out_sew    = out_sew_r;
    assign out_vec0   = out_vec0_r;
    assign out_vec1   = out_vec1_r;
    assign out_be     = out_be_r;
    assign busy       = (state_r != IDLE) | s1_valid_r | s2_valid_r | out_valid_r;

endmodule

// File: tb/tb_vslide_issue.sv
// Testbench for vslide_issue: cycle-indexed expectation model plus directed
// scenarios with hand-computed literal checks.
`timescale 1ns/1ps
module tb_vslide_issue;

    localparam int DW = 64;
    localparam int SW = 2;
    localparam int BW = 8;
    localparam int AW = 10;
    localparam int VW = 11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_vs2_addr;
    logic [DW-1:0] req_scalar;
    logic [VW-1:0] req_vl;
    logic [SW-1:0] req_sew;
    logic          req_dir;
    logic          req_insert;
    logic          rf_rd_en;
    logic [AW-1:0] rf_rd_addr;
    logic [DW-1:0] rf_rd_data;
    logic          out_valid, out_start, out_end, out_opSel, out_insert;
    logic [SW-1:0] out_sew;
    logic [DW-1:0] out_vec0, out_vec1;
    logic [BW-1:0] out_be;
    logic          busy;

    always #5 clk = ~clk;

    vslide_issue dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_vs2_addr (req_vs2_addr),
        .req_scalar   (req_scalar),
        .req_vl       (req_vl),
        .req_sew      (req_sew),
        .req_dir      (req_dir),
`ifdef VSLIDE_ISSUE_INSERT_EN
        .req_insert   (req_insert),
`endif
        .rf_rd_en     (rf_rd_en),
        .rf_rd_addr   (rf_rd_addr),
        .rf_rd_data   (rf_rd_data),
        .out_valid    (out_valid),
        .out_start    (out_start),
        .out_end      (out_end),
        .out_opSel    (out_opSel),
        .out_insert   (out_insert),
        .out_sew      (out_sew),
        .out_vec0     (out_vec0),
        .out_vec1     (out_vec1),
        .out_be       (out_be),
        .busy         (busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [142:0] act, input logic [142:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Register-file contents: a recognisable pattern per address.
    function automatic logic [63:0] mem_word(input int a);
        logic [9:0] a10;
        a10 = a[9:0];
        return {16'hC0DE, 6'd0, a10, 6'd0, a10, 16'h5A5A};
    endfunction

    // Register-file responder: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (rf_rd_en) rf_rd_data <= mem_word(int'(rf_rd_addr));
        else          rf_rd_data <= 64'hDEAD_BEEF_DEAD_BEEF;
    end

    // ---------------- Expectation model ----------------
    // Keys are edge numbers; an entry describes what must be seen after that edge.
    typedef logic [142:0] pbeat_t;
    pbeat_t exp_out[int];
    int     exp_rd[int];
    bit     exp_busy[int];
    int     cyc = 0;
    int     ready_at = 0;
    int     accept_cnt = 0;
    int     accept_edge = 0;
    int     m_bytes, m_n, m_addr;
    logic [7:0] m_be;
    logic   m_ins;

    task automatic purge(input int from);
        int keys[$];
        foreach (exp_out[k]) if (k >= from) keys.push_back(k);
        foreach (keys[i]) exp_out.delete(keys[i]);
        keys.delete();
        foreach (exp_rd[k]) if (k >= from) keys.push_back(k);
        foreach (keys[i]) exp_rd.delete(keys[i]);
        keys.delete();
        foreach (exp_busy[k]) if (k >= from) keys.push_back(k);
        foreach (keys[i]) exp_busy.delete(keys[i]);
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            purge(cyc);
            ready_at = cyc + 1;
        end else if (req_valid && cyc >= ready_at) begin
            accept_cnt  = accept_cnt + 1;
            accept_edge = cyc;
`ifdef VSLIDE_ISSUE_INSERT_EN
            m_ins = req_insert;
`else
            m_ins = 1'b0;
`endif
            m_bytes = int'(req_vl) * (1 << req_sew);
            m_n     = (m_bytes + 7) / 8;
            for (int k = 0; k < m_n; k++) begin
                m_addr = (int'(req_vs2_addr) + k) % 1024;
                if (k < m_n - 1 || (m_bytes % 8) == 0) m_be = 8'hFF;
                else m_be = 8'((1 << (m_bytes % 8)) - 1);
                exp_rd[cyc + k] = m_addr;
                exp_out[cyc + k + 2] = {1'b1, (k == 0), (k == m_n - 1), req_dir, m_ins,
                                        req_sew, m_be, mem_word(m_addr), req_scalar};
            end
            if (m_n > 0) begin
                for (int k = 0; k < m_n + 2; k++) exp_busy[cyc + k] = 1'b1;
                ready_at = cyc + m_n + 1;
            end else begin
                ready_at = cyc + 1;
            end
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    logic [10:0]  c_rd;
    logic [9:0]   c_addr;
    pbeat_t       c_out;
    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("ready", 143'(req_ready), 143'(!exp_rd.exists(cyc)));
            chk("busy", 143'(busy), 143'(exp_busy.exists(cyc)));
            if (exp_rd.exists(cyc)) begin
                c_addr = exp_rd[cyc][9:0];
                c_rd   = {1'b1, c_addr};
            end else begin
                c_rd = 11'd0;
            end
            chk("rd_port", 143'({rf_rd_en, rf_rd_addr}), 143'(c_rd));
            c_out = exp_out.exists(cyc) ? exp_out[cyc] : 143'd0;
            chk("out_beat", {out_valid, out_start, out_end, out_opSel, out_insert,
                             out_sew, out_be, out_vec0, out_vec1}, c_out);
        end
    end

    // Logs of observed reads and beats for the directed literal checks.
    typedef struct {
        int          cyc;
        logic        start;
        logic        fin;
        logic [7:0]  be;
        logic        opsel;
        logic [63:0] vec0;
        logic [63:0] vec1;
    } beat_s;
    beat_s     beats[$];
    logic [9:0] rd_log[$];

    always @(negedge clk) begin
        if (rf_rd_en) rd_log.push_back(rf_rd_addr);
        if (out_valid) beats.push_back('{cyc, out_start, out_end, out_be, out_opSel, out_vec0, out_vec1});
    end

    task automatic clr();
        rd_log.delete();
        beats.delete();
    endtask

    task automatic send(input int vl, input int sew, input int dir, input int addr,
                        input logic [63:0] scalar, input bit hold);
        int prev;
        bit ok;
        req_vl       = VW'(vl);
        req_sew      = SW'(sew);
        req_dir      = dir[0];
        req_vs2_addr = AW'(addr);
        req_scalar   = scalar;
        req_valid    = 1'b1;
        prev = accept_cnt;
        ok   = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (accept_cnt != prev) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors = errors + 1;
            checks = checks + 1;
            $display("FAIL accept_timeout: request vl=%0d not accepted within 50 cycles", vl);
        end
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int t;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_vs2_addr = '0; req_scalar = '0;
        req_vl = '0; req_sew = '0; req_dir = 1'b0; req_insert = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 143'(req_ready), 143'(1'b1));
        chk("reset_valid", 143'(out_valid), 143'(1'b0));
        rst_n = 1'b1;
        @(negedge clk);

        // Single chunk: vl=8 bytes, slide down.
        clr();
        send(8, 0, 1, 'h010, 64'hAB, 1'b0);
        t = accept_edge;
        idle(5);
        chk("t1_nrd", 143'(rd_log.size()), 143'(1));
        chk("t1_nbeat", 143'(beats.size()), 143'(1));
        if (rd_log.size() == 1) chk("t1_addr", 143'(rd_log[0]), 143'(10'h010));
        if (beats.size() == 1) begin
            chk("t1_start", 143'(beats[0].start), 143'(1'b1));
            chk("t1_end", 143'(beats[0].fin), 143'(1'b1));
            chk("t1_be", 143'(beats[0].be), 143'(8'hFF));
            chk("t1_opsel", 143'(beats[0].opsel), 143'(1'b1));
            chk("t1_vec1", 143'(beats[0].vec1), 143'(64'hAB));
            chk("t1_latency", 143'(beats[0].cyc - t), 143'(2));
        end

        // Three chunks, 20 bytes, slide up.
        clr();
        send(5, 2, 0, 'h100, 64'h1122_3344_5566_7788, 1'b0);
        idle(6);
        chk("t2_nbeat", 143'(beats.size()), 143'(3));
        chk("t2_nrd", 143'(rd_log.size()), 143'(3));
        if (beats.size() == 3) begin
            chk("t2_be0", 143'(beats[0].be), 143'(8'hFF));
            chk("t2_be1", 143'(beats[1].be), 143'(8'hFF));
            chk("t2_be2", 143'(beats[2].be), 143'(8'h0F));
            chk("t2_starts", 143'({beats[0].start, beats[1].start, beats[2].start}), 143'(3'b100));
            chk("t2_ends", 143'({beats[0].fin, beats[1].fin, beats[2].fin}), 143'(3'b001));
            chk("t2_nobubble", 143'(beats[2].cyc - beats[0].cyc), 143'(2));
        end
        if (rd_log.size() == 3)
            chk("t2_addrs", 143'({rd_log[0], rd_log[1], rd_log[2]}), 143'({10'h100, 10'h101, 10'h102}));

        // Zero-length request.
        clr();
        send(0, 1, 0, 'h055, 64'h5, 1'b0);
        chk("t3_ready", 143'(req_ready), 143'(1'b1));
        idle(5);
        chk("t3_nrd", 143'(rd_log.size()), 143'(0));
        chk("t3_nbeat", 143'(beats.size()), 143'(0));

        // Address wrap.
        clr();
        send(2, 3, 1, 'h3FF, 64'hFEED, 1'b0);
        idle(5);
        chk("t4_nrd", 143'(rd_log.size()), 143'(2));
        if (rd_log.size() == 2)
            chk("t4_addrs", 143'({rd_log[0], rd_log[1]}), 143'({10'h3FF, 10'h000}));
        if (beats.size() == 2)
            chk("t4_be", 143'({beats[0].be, beats[1].be}), 143'(16'hFFFF));

        // Back-to-back with req_valid held high.
        clr();
        send(3, 3, 0, 'h200, 64'hA, 1'b1);
        send(9, 0, 1, 'h210, 64'hB, 1'b0);
        idle(8);
        chk("t5_nbeat", 143'(beats.size()), 143'(5));
        if (beats.size() == 5) begin
            chk("t5_a_end", 143'(beats[2].fin), 143'(1'b1));
            chk("t5_b_start", 143'(beats[3].start), 143'(1'b1));
            chk("t5_gap", 143'(beats[3].cyc - beats[2].cyc), 143'(2));
            chk("t5_b_be", 143'(beats[4].be), 143'(8'h01));
            chk("t5_b_vec1", 143'(beats[3].vec1), 143'(64'hB));
        end

        // Reset in the middle of a three-chunk stream.
        send(3, 3, 1, 'h020, 64'hC, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_valid", 143'(out_valid), 143'(1'b0));
        chk("t6_ready", 143'(req_ready), 143'(1'b1));
        chk("t6_rden", 143'(rf_rd_en), 143'(1'b0));
        chk("t6_busy", 143'(busy), 143'(1'b0));
        rst_n = 1'b1;
        clr();
        send(2, 3, 0, 'h040, 64'hD, 1'b0);
        idle(5);
        chk("t6_nbeat", 143'(beats.size()), 143'(2));
        if (beats.size() == 2) begin
            chk("t6_start", 143'(beats[0].start), 143'(1'b1));
            chk("t6_vec0", 143'(beats[0].vec0), 143'(mem_word('h040)));
        end
        if (rd_log.size() == 2) chk("t6_addr", 143'(rd_log[0]), 143'(10'h040));

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
